regfile_write_arbiter: RTL and testbench

Shares the single write port of the 8×8-bit register file between two write-back requesters:
- port A: ALU result;
- port B: data-memory load return.

It arbitrates round-robin, registers the winning write into the file's IN/INADDRESS/WRITE inputs, and keeps a per-register busy scoreboard. The decode stage uses that scoreboard to stall reads of registers whose write is still in flight. It sits between the execute/memory stages and the register file.

---
 rtl/regfile_write_arbiter_pkg.sv | 21 ++
 rtl/regfile_write_arbiter_rr.sv | 45 ++++
 rtl/regfile_write_arbiter.sv | 87 ++++++++
 tb/tb_regfile_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared constants and types for the register-file write arbiter.
//   DATA_W     : register data width
//   ADDR_W     : register address width
//   NREG       : number of registers (2**ADDR_W)
//   port_sel_e : identifies a write-back requester (PORT_A = ALU,
//                PORT_B = data-memory load return)
// ---------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_sel_e;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter. The grant is combinational from the
// requests and the LAST pointer. A sole requester always wins. On a tie,
// the port that did not win last time wins.
//   CLK    : system clock
//   RESET  : asynchronous active-low reset (LAST returns to PORT_B)
//   req[0] : port A request    req[1] : port B request
//   gnt    : one-hot grant, bit order matches req
// ---------------------------------------------------------------------------
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_sel_e last;

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so that no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || last == PORT_B)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every
    // flop samples the values present before the clock edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            last <= PORT_B;
        end else if (gnt[0]) begin
            last <= PORT_A;
        end else if (gnt[1]) begin
            last <= PORT_B;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Shares the single register-file write port between the ALU (port A) and
// the load-return path (port B). Arbitrates round-robin, registers the
// winning write onto WRITE/INADDRESS/IN, and publishes a per-register busy
// scoreboard so decode can stall reads of registers with writes in flight.
//   CLK, RESET               : clock, asynchronous active-low reset
//   REQ_x/ADDR_x/DATA_x      : requester x write request, held until GNT_x
//   GNT_x                    : requester x accepted at this rising edge
//   WRITE/INADDRESS/IN       : registered write to the register file
//   RD1ADDR/RD2ADDR          : read addresses being decoded
//   BUSY                     : bit r set while a write to r is outstanding
//   STALL                    : a decoded read address hits BUSY
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,

    input  logic              REQ_A,
    input  logic [ADDR_W-1:0] ADDR_A,
    input  logic [DATA_W-1:0] DATA_A,
    output logic              GNT_A,

    input  logic              REQ_B,
    input  logic [ADDR_W-1:0] ADDR_B,
    input  logic [DATA_W-1:0] DATA_B,
    output logic              GNT_B,

    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN,

    input  logic [ADDR_W-1:0] RD1ADDR,
    input  logic [ADDR_W-1:0] RD2ADDR,
    output logic [NREG-1:0]   BUSY,
    output logic              STALL
);

    logic [1:0] gnt;

    rr_arbiter2 u_arb (
        .CLK   (CLK),
        .RESET (RESET),
        .req   ({REQ_B, REQ_A}),
        .gnt   (gnt)
    );

    assign GNT_A = gnt[0];
    assign GNT_B = gnt[1];

    // Output stage. INADDRESS/IN hold between writes; only WRITE pulses.
    // NOTE: the address/data registers are reset too, so the file never
    // sees an X address, and a write registered before reset is dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            WRITE     <= 1'b0;
            INADDRESS <= '0;
            IN        <= '0;
        end else if (GNT_A) begin
            WRITE     <= 1'b1;
            INADDRESS <= ADDR_A;
            IN        <= DATA_A;
        end else if (GNT_B) begin
            WRITE     <= 1'b1;
            INADDRESS <= ADDR_B;
            IN        <= DATA_B;
        end else begin
            WRITE     <= 1'b0;
        end
    end

    // Scoreboard: a register is busy while a request for it is queued at
    // either port or while its registered write has not yet been committed.
    always_comb begin
        BUSY = '0;
        for (int r = 0; r < NREG; r++) begin
            BUSY[r] = (REQ_A && ADDR_A == ADDR_W'(r)) ||
                      (REQ_B && ADDR_B == ADDR_W'(r)) ||
                      (WRITE && INADDRESS == ADDR_W'(r));
        end
    end

    assign STALL = BUSY[RD1ADDR] | BUSY[RD2ADDR];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              REQ_A = 1'b0, REQ_B = 1'b0;
    logic [ADDR_W-1:0] ADDR_A = '0, ADDR_B = '0;
    logic [DATA_W-1:0] DATA_A = '0, DATA_B = '0;
    logic              GNT_A, GNT_B, WRITE, STALL;
    logic [ADDR_W-1:0] INADDRESS;
    logic [DATA_W-1:0] IN;
    logic [ADDR_W-1:0] RD1ADDR = '0, RD2ADDR = '0;
    logic [NREG-1:0]   BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who won last, what write is in flight, and the
    // register-file contents expected vs. those observed on the write port.
    bit              m_last_b = 1'b1;
    bit              m_write  = 1'b0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    bit              was_ga = 1'b0, was_gb = 1'b0;
    logic [DATA_W-1:0] exp_rf [NREG];
    logic [DATA_W-1:0] obs_rf [NREG];

    regfile_write_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .REQ_A(REQ_A), .ADDR_A(ADDR_A), .DATA_A(DATA_A), .GNT_A(GNT_A),
        .REQ_B(REQ_B), .ADDR_B(ADDR_B), .DATA_B(DATA_B), .GNT_B(GNT_B),
        .WRITE(WRITE), .INADDRESS(INADDRESS), .IN(IN),
        .RD1ADDR(RD1ADDR), .RD2ADDR(RD2ADDR), .BUSY(BUSY), .STALL(STALL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    task automatic model_reset();
        m_last_b = 1'b1;
        m_write  = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
        was_ga   = 1'b0;
        was_gb   = 1'b0;
    endtask

    // One clock cycle: compare every output against the model with the
    // inputs the bench drove at the preceding falling edge, then advance.
    task automatic run_cycle(input string tag);
        bit ga, gb, stall;
        logic [NREG-1:0] busy;
        #1;
        ga = REQ_A && (!REQ_B || m_last_b);
        gb = REQ_B && !ga;
        busy = '0;
        if (REQ_A)   busy[ADDR_A]  = 1'b1;
        if (REQ_B)   busy[ADDR_B]  = 1'b1;
        if (m_write) busy[m_waddr] = 1'b1;
        stall = busy[RD1ADDR] || busy[RD2ADDR];

        n_checks++;
        if ({GNT_A, GNT_B} !== {ga, gb}) begin
            n_fail++;
            $display("FAIL %s.gnt: got %b%b expected %b%b", tag, GNT_A, GNT_B, ga, gb);
        end
        n_checks++;
        if ({WRITE, INADDRESS, IN} !== {m_write, m_waddr, m_wdata}) begin
            n_fail++;
            $display("FAIL %s.wport: got w=%b a=%0d d=%h expected w=%b a=%0d d=%h",
                     tag, WRITE, INADDRESS, IN, m_write, m_waddr, m_wdata);
        end
        n_checks++;
        if (BUSY !== busy || STALL !== stall) begin
            n_fail++;
            $display("FAIL %s.busy: got %b/%b expected %b/%b", tag, BUSY, STALL, busy, stall);
        end

        if (WRITE === 1'b1) obs_rf[INADDRESS] = IN;
        if (m_write)        exp_rf[m_waddr]   = m_wdata;

        @(posedge CLK);
        if (ga) begin
            m_write = 1'b1; m_waddr = ADDR_A; m_wdata = DATA_A; m_last_b = 1'b0;
        end else if (gb) begin
            m_write = 1'b1; m_waddr = ADDR_B; m_wdata = DATA_B; m_last_b = 1'b1;
        end else begin
            m_write = 1'b0;
        end
        was_ga = ga;
        was_gb = gb;
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b0;
        REQ_A = 1'b0;
        REQ_B = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if ({WRITE, INADDRESS, IN, BUSY, STALL, GNT_A, GNT_B} !== '0) begin
            n_fail++;
            $display("FAIL reset: got w=%b a=%0d d=%h busy=%b stall=%b gnt=%b%b expected all zero",
                     WRITE, INADDRESS, IN, BUSY, STALL, GNT_A, GNT_B);
        end
        run_cycle("reset_idle");
    endtask

    task automatic test_single();
        REQ_A = 1'b1; ADDR_A = 3'd3; DATA_A = 8'h5A;
        RD1ADDR = 3'd3; RD2ADDR = 3'd0;
        run_cycle("single_req");
        REQ_A = 1'b0;
        #1;
        n_checks++;
        if ({WRITE, INADDRESS, IN} !== {1'b1, 3'd3, 8'h5A}) begin
            n_fail++;
            $display("FAIL single_write: got w=%b a=%0d d=%h expected w=1 a=3 d=5a", WRITE, INADDRESS, IN);
        end
        run_cycle("single_wr");
        run_cycle("single_clear");
        n_checks++;
        if (BUSY[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_clear: got %b expected 0", BUSY[3]);
        end
    endtask

    task automatic test_contention();
        bit prev_a;
        REQ_A = 1'b1; ADDR_A = 3'd1; DATA_A = 8'h11;
        REQ_B = 1'b1; ADDR_B = 3'd2; DATA_B = 8'h22;
        for (int i = 0; i < 8; i++) begin
            #1;
            n_checks++;
            if ((GNT_A ^ GNT_B) !== 1'b1 || (i > 0 && GNT_A === prev_a)) begin
                n_fail++;
                $display("FAIL contention_alt[%0d]: got gnt=%b%b expected alternate of last a=%b",
                         i, GNT_A, GNT_B, prev_a);
            end
            if (i > 0) begin
                n_checks++;
                if (WRITE !== 1'b1) begin
                    n_fail++;
                    $display("FAIL contention_write[%0d]: got %b expected 1", i, WRITE);
                end
            end
            prev_a = GNT_A;
            run_cycle("contention");
            if (was_ga) DATA_A = DATA_A + 8'h01;
            if (was_gb) DATA_B = DATA_B + 8'h01;
        end
        REQ_A = 1'b0; REQ_B = 1'b0;
        run_cycle("contention_drain");
    endtask

    task automatic test_same_address();
        apply_reset();
        REQ_A = 1'b1; ADDR_A = 3'd5; DATA_A = 8'h10;
        REQ_B = 1'b1; ADDR_B = 3'd5; DATA_B = 8'h20;
        #1;
        n_checks++;
        if ({GNT_A, GNT_B} !== 2'b10) begin
            n_fail++;
            $display("FAIL same_addr_first: got %b%b expected 10", GNT_A, GNT_B);
        end
        run_cycle("same_a");
        REQ_A = 1'b0;
        run_cycle("same_b");
        REQ_B = 1'b0;
        run_cycle("same_drain0");
        run_cycle("same_drain1");
        n_checks++;
        if (obs_rf[5] !== 8'h20) begin
            n_fail++;
            $display("FAIL same_addr_final: got %h expected 20", obs_rf[5]);
        end
    endtask

    task automatic test_hazard();
        bit exp_stall [3] = '{1'b1, 1'b1, 1'b0};
        RD1ADDR = 3'd4; RD2ADDR = 3'd0;
        REQ_B = 1'b1; ADDR_B = 3'd4; DATA_B = 8'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (STALL !== exp_stall[i]) begin
                n_fail++;
                $display("FAIL hazard_stall[%0d]: got %b expected %b", i, STALL, exp_stall[i]);
            end
            run_cycle("hazard");
            REQ_B = 1'b0;
        end
        RD1ADDR = 3'd6;
        REQ_B = 1'b1; ADDR_B = 3'd4; DATA_B = 8'h45;
        #1;
        n_checks++;
        if (STALL !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_other: got %b expected 0", STALL);
        end
        run_cycle("hazard_other");
        REQ_B = 1'b0;
        run_cycle("hazard_drain");
    endtask

    task automatic test_reset_mid();
        REQ_A = 1'b1; ADDR_A = 3'd7; DATA_A = 8'hC3;
        run_cycle("rmid_req");
        REQ_A = 1'b0;
        #1;
        n_checks++;
        if (WRITE !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_pre: got %b expected 1", WRITE);
        end
        RESET = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({WRITE, INADDRESS, IN} !== '0) begin
            n_fail++;
            $display("FAIL rmid_clear: got w=%b a=%0d d=%h expected 0/0/0", WRITE, INADDRESS, IN);
        end
        @(negedge CLK);
        RESET = 1'b1;
        REQ_A = 1'b1; ADDR_A = 3'd1; DATA_A = 8'h01;
        REQ_B = 1'b1; ADDR_B = 3'd2; DATA_B = 8'h02;
        #1;
        n_checks++;
        if ({GNT_A, GNT_B} !== 2'b10) begin
            n_fail++;
            $display("FAIL rmid_tie: got %b%b expected 10", GNT_A, GNT_B);
        end
        run_cycle("rmid_a");
        REQ_A = 1'b0;
        run_cycle("rmid_b");
        REQ_B = 1'b0;
        run_cycle("rmid_drain");
    endtask

    task automatic test_idle();
        RD1ADDR = 3'd2; RD2ADDR = 3'd5;
        for (int i = 0; i < 10; i++) begin
            run_cycle("idle");
        end
        n_checks++;
        if (BUSY !== '0 || STALL !== 1'b0 || WRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_end: got busy=%b stall=%b w=%b expected 0/0/0", BUSY, STALL, WRITE);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            // A requester holds its request until granted, then may idle.
            if (!REQ_A || was_ga) begin
                REQ_A  = ($urandom_range(0, 3) != 0);
                ADDR_A = ADDR_W'($urandom_range(0, NREG - 1));
                DATA_A = DATA_W'($urandom);
            end
            if (!REQ_B || was_gb) begin
                REQ_B  = ($urandom_range(0, 3) != 0);
                ADDR_B = ADDR_W'($urandom_range(0, NREG - 1));
                DATA_B = DATA_W'($urandom);
            end
            RD1ADDR = ADDR_W'($urandom_range(0, NREG - 1));
            RD2ADDR = ADDR_W'($urandom_range(0, NREG - 1));
            run_cycle("random");
        end
        REQ_A = 1'b0; REQ_B = 1'b0;
        run_cycle("random_drain0");
        run_cycle("random_drain1");
        for (int r = 0; r < NREG; r++) begin
            n_checks++;
            if (obs_rf[r] !== exp_rf[r]) begin
                n_fail++;
                $display("FAIL random_rf[%0d]: got %h expected %h", r, obs_rf[r], exp_rf[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            exp_rf[r] = '0;
            obs_rf[r] = '0;
        end
        test_reset();
        test_single();
        test_contention();
        test_same_address();
        test_hazard();
        test_reset_mid();
        test_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
